// File: rtl/fiber_frame_arbiter_pkg.sv
// ============================================================================
// Module   : fiber_frame_arbiter_pkg
// Brief    : Shared types and constants for the fiber frame arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fiber_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_CLOSE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] C_TRAILER_DEFAULT = 32'hDEADBEEF;
    localparam int          C_DATA_W          = 32;
    localparam int          C_FRAME_CNT_W     = 16;
    localparam int          C_TIMEOUT_CNT_W   = 8;
    localparam int          C_WORD_CNT_W      = 10;

    function automatic logic [C_TIMEOUT_CNT_W-1:0] sat_inc(
        input logic [C_TIMEOUT_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fiber_frame_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : fiber_frame_arbiter_rr_arbiter
// Brief    : Combinational one-hot winner select, round-robin after i_ptr.
//            FIXED_PRIORITY_EN selects lowest-index-wins instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fiber_frame_arbiter_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_SRC-1:0] o_grant
);

    logic w_found;

`ifdef FIXED_PRIORITY_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!w_found && i_req[k]) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] w_idx;

    // Search starts one past the last served source so it gets lowest priority.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % N_SRC);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/fiber_frame_arbiter.sv
// ============================================================================
// Module   : fiber_frame_arbiter
// Brief    : Whole-frame arbiter of N sources onto one TX FIFO write port,
//            with runaway-frame watchdog. Option macro: FIXED_PRIORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fiber_frame_arbiter
    import fiber_frame_arbiter_pkg::*;
#(
    parameter int          N_SRC   = 4,
    parameter int          MAX_LEN = 64,
    parameter logic [31:0] TRAILER = C_TRAILER_DEFAULT
) (
    input  logic                      CK,
    input  logic                      RSTb,
    input  logic                      ENABLE,
    input  logic [N_SRC-1:0]          REQ,
    input  logic [N_SRC-1:0]          SRC_WR,
    input  logic [C_DATA_W*N_SRC-1:0] SRC_DATA,
    input  logic [N_SRC-1:0]          SRC_EOF,
    output logic [N_SRC-1:0]          SRC_FULL,
    output logic [N_SRC-1:0]          GRANT,
    input  logic                      FULL,
    output logic                      OUT_WR,
    output logic [C_DATA_W-1:0]       OUT_DATA,
    output logic                      OUT_EOF,
    output logic [C_FRAME_CNT_W-1:0]  FRAME_CNT,
    output logic [C_TIMEOUT_CNT_W-1:0] TIMEOUT_CNT
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [C_WORD_CNT_W-1:0] C_LAST_CNT = C_WORD_CNT_W'(MAX_LEN - 1);

    state_t                     state_q, state_d;
    logic [N_SRC-1:0]           grant_q, grant_d;
    logic [IDX_W-1:0]           gidx_q, gidx_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [C_WORD_CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                       out_wr_q, out_wr_d;
    logic [C_DATA_W-1:0]        out_data_q, out_data_d;
    logic                       out_eof_q, out_eof_d;
    logic [C_FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [C_TIMEOUT_CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

    logic [C_DATA_W-1:0] w_src_data [N_SRC];
    logic [N_SRC-1:0]    w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_start;
    logic                w_acc;
    logic                w_acc_eof;
    logic                w_wd_hit;
    logic                w_drain_done;

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign w_src_data[i] = SRC_DATA[C_DATA_W*i +: C_DATA_W];
    end

    fiber_frame_arbiter_rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (REQ),
        .i_ptr   (ptr_q),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_arb_grant[i]) begin
                w_arb_idx = IDX_W'(i);
            end
        end
    end

    // Only the granted source in XFER with downstream room may write.
    assign SRC_FULL     = ~grant_q | {N_SRC{FULL}} | {N_SRC{state_q != ST_XFER}};
    assign w_start      = ENABLE & (|REQ);
    assign w_acc        = SRC_WR[gidx_q] & ~SRC_FULL[gidx_q];
    assign w_acc_eof    = w_acc & SRC_EOF[gidx_q];
    assign w_wd_hit     = w_acc & ~SRC_EOF[gidx_q] & (wcnt_q == C_LAST_CNT);
    assign w_drain_done = ~REQ[gidx_q] | (SRC_WR[gidx_q] & SRC_EOF[gidx_q]);

    always_ff @(posedge CK or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_start)      state_d = ST_XFER;
            ST_XFER: begin
                if (w_acc_eof)          state_d = ST_IDLE;
                else if (w_wd_hit)      state_d = ST_CLOSE;
            end
            ST_CLOSE: if (!FULL)        state_d = ST_DRAIN;
            ST_DRAIN: if (w_drain_done) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        wcnt_d        = wcnt_q;
        out_wr_d      = 1'b0;
        out_data_d    = out_data_q;
        out_eof_d     = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    grant_d = w_arb_grant;
                    gidx_d  = w_arb_idx;
                    wcnt_d  = '0;
                end
            end
            ST_XFER: begin
                if (w_acc) begin
                    out_wr_d   = 1'b1;
                    out_data_d = w_src_data[gidx_q];
                    out_eof_d  = SRC_EOF[gidx_q];
                    wcnt_d     = wcnt_q + 1'b1;
                    if (SRC_EOF[gidx_q]) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        ptr_d       = gidx_q;
                        grant_d     = '0;
                    end
                end
            end
            ST_CLOSE: begin
                if (!FULL) begin
                    out_wr_d      = 1'b1;
                    out_data_d    = TRAILER;
                    out_eof_d     = 1'b1;
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                    frame_cnt_d   = frame_cnt_q + 1'b1;
                    ptr_d         = gidx_q;
                    grant_d       = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK or negedge RSTb) begin
        if (!RSTb) begin
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= '0;
            wcnt_q        <= '0;
            out_wr_q      <= 1'b0;
            out_data_q    <= '0;
            out_eof_q     <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            wcnt_q        <= wcnt_d;
            out_wr_q      <= out_wr_d;
            out_data_q    <= out_data_d;
            out_eof_q     <= out_eof_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign GRANT       = grant_q;
    assign OUT_WR      = out_wr_q;
    assign OUT_DATA    = out_data_q;
    assign OUT_EOF     = out_eof_q;
    assign FRAME_CNT   = frame_cnt_q;
    assign TIMEOUT_CNT = timeout_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fiber_frame_arbiter.sv
// ============================================================================
// Module   : tb_fiber_frame_arbiter
// Brief    : Scoreboard bench for fiber_frame_arbiter (N_SRC=4, MAX_LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fiber_frame_arbiter;

    localparam int          N  = 4;
    localparam int          ML = 8;
    localparam logic [31:0] TR = 32'hDEADBEEF;

    logic            CK = 1'b0;
    logic            RSTb = 1'b0;
    logic            ENABLE = 1'b0;
    logic            FULL = 1'b0;
    logic [N-1:0]    REQ = '0;
    logic [N-1:0]    SRC_WR = '0;
    logic [N-1:0]    SRC_EOF = '0;
    logic [32*N-1:0] SRC_DATA = '0;
    wire  [N-1:0]    SRC_FULL;
    wire  [N-1:0]    GRANT;
    wire             OUT_WR;
    wire  [31:0]     OUT_DATA;
    wire             OUT_EOF;
    wire  [15:0]     FRAME_CNT;
    wire  [7:0]      TIMEOUT_CNT;

    fiber_frame_arbiter #(.N_SRC(N), .MAX_LEN(ML), .TRAILER(TR)) dut (
        .CK(CK), .RSTb(RSTb), .ENABLE(ENABLE), .REQ(REQ), .SRC_WR(SRC_WR),
        .SRC_DATA(SRC_DATA), .SRC_EOF(SRC_EOF), .SRC_FULL(SRC_FULL),
        .GRANT(GRANT), .FULL(FULL), .OUT_WR(OUT_WR), .OUT_DATA(OUT_DATA),
        .OUT_EOF(OUT_EOF), .FRAME_CNT(FRAME_CNT), .TIMEOUT_CNT(TIMEOUT_CNT)
    );

    always #5 CK = ~CK;

    typedef struct { logic [31:0] d; logic e; } word_t;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    int    glog[$];
    int    pend[N], flen[N], fidx[N], fseq[N];
    bit    blind[N];
    int    seq_ctr = 0;
    int    cfg_len = 4;
    bit    full_rand = 1'b0;
    int    burst_src = -1, burst_at = 0, burst_left = 0;
    int    last_served = 0;
    int    exp_frames = 0, exp_timeouts = 0;
    bit    mon_en = 1'b0;
    logic [N-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int i, input int s, input int k);
        return {4'(i), 12'(s), 16'(k)};
    endfunction

    function automatic void start_frame(input int i, input int len);
        flen[i]  = len;
        fidx[i]  = 0;
        blind[i] = 1'b0;
        fseq[i]  = seq_ctr;
        seq_ctr++;
    endfunction

    function automatic void finish_frame(input int i);
        pend[i]--;
        if (pend[i] > 0)
            start_frame(i, (cfg_len > 0) ? cfg_len : int'($urandom_range(1, 12)));
    endfunction

    // Reference arbitration rule: who should win given the requests and the last served source.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r);
`ifdef FIXED_PRIORITY_EN
        for (int k = 0; k < N; k++)
            if (r[k]) return N'(1) << k;
`else
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_served + k) % N;
            if (r[j]) return N'(1) << j;
        end
`endif
        return '0;
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (pend[i] > 0) return 1'b0;
        return (exp_q.size() == 0) && (GRANT == '0);
    endfunction

    // One cycle of source behaviour; pushes every word the arbiter must forward.
    task automatic drive_cycle();
        @(negedge CK);
        if (burst_left > 0 && burst_src >= 0 && fidx[burst_src] >= burst_at) begin
            FULL = 1'b1;
            burst_left--;
        end else begin
            FULL = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        #1;
        if (FULL) check("src_full_on_full", 32'(SRC_FULL), 32'hF);
        for (int i = 0; i < N; i++) begin
            logic eof;
            REQ[i]     = (pend[i] > 0);
            SRC_WR[i]  = 1'b0;
            SRC_EOF[i] = 1'b0;
            if (!SRC_FULL[i]) check("src_full_rule", 32'({GRANT[i], FULL}), 32'h2);
            if (pend[i] > 0) begin
                SRC_DATA[32*i +: 32] = word_of(i, fseq[i], fidx[i]);
                eof = (fidx[i] == flen[i] - 1);
                if (blind[i]) begin
                    if (!GRANT[i]) begin
                        SRC_WR[i]  = 1'b1;
                        SRC_EOF[i] = eof;
                        fidx[i]++;
                        if (eof) finish_frame(i);
                    end
                end else begin
                    SRC_WR[i]  = ($urandom_range(0, 3) != 0);
                    SRC_EOF[i] = eof;
                    if (SRC_WR[i] && !SRC_FULL[i]) begin
                        exp_q.push_back('{d: word_of(i, fseq[i], fidx[i]), e: eof});
                        fidx[i]++;
                        if (eof) begin
                            exp_frames++;
                            last_served = i;
                            finish_frame(i);
                        end else if (fidx[i] == ML) begin
                            exp_q.push_back('{d: TR, e: 1'b1});
                            exp_frames++;
                            exp_timeouts++;
                            last_served = i;
                            blind[i] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = budget;
        do begin
            drive_cycle();
            n--;
        end while (!all_idle() && n > 0);
        if (!all_idle()) begin
            checks++;
            errors++;
            $display("FAIL %s: not idle after %0d cycles, %0d words still expected", name, budget, exp_q.size());
        end
        repeat (3) drive_cycle();
    endtask

    always @(posedge CK) begin
        #1;
        if (mon_en) begin
            if (prev_grant == '0 && GRANT != '0) begin
                check("grant_pick", 32'(GRANT), 32'(model_pick(REQ)));
                check("grant_enable", 32'(ENABLE), 32'd1);
                for (int k = 0; k < N; k++)
                    if (GRANT[k]) glog.push_back(k);
            end
            if (OUT_WR) begin
                check("no_wr_after_full", 32'(FULL), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_word: got unexpected write %h eof %b, expected none", OUT_DATA, OUT_EOF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("out_data", OUT_DATA, w.d);
                    check("out_eof", 32'(OUT_EOF), 32'(w.e));
                end
            end else if (OUT_EOF) begin
                check("eof_without_wr", 32'(OUT_EOF), 32'd0);
            end
        end
        prev_grant = GRANT;
    end

    initial begin
        int exp_b[8];
        int n;
`ifdef FIXED_PRIORITY_EN
        exp_b = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
        exp_b = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; flen[i] = 0; fidx[i] = 0; fseq[i] = 0; blind[i] = 1'b0;
        end

        // Reset values
        repeat (3) @(posedge CK);
        #1;
        check("rst_grant", 32'(GRANT), 32'd0);
        check("rst_out_wr", 32'(OUT_WR), 32'd0);
        check("rst_out_data", OUT_DATA, 32'd0);
        check("rst_out_eof", 32'(OUT_EOF), 32'd0);
        check("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
        check("rst_timeout_cnt", 32'(TIMEOUT_CNT), 32'd0);
        check("rst_src_full", 32'(SRC_FULL), 32'hF);
        @(negedge CK);
        RSTb   = 1'b1;
        mon_en = 1'b1;
        ENABLE = 1'b1;

        // Single source, frame of exactly MAX_LEN words ending in EOF
        cfg_len = 8; pend[0] = 1; start_frame(0, 8);
        run_until_idle("single_frame", 200);
        check("single_frame_cnt", 32'(FRAME_CNT), 32'd1);
        check("single_timeout_cnt", 32'(TIMEOUT_CNT), 32'd0);

        // All sources, two 4-word frames each
        glog.delete();
        cfg_len = 4;
        for (int i = 0; i < N; i++) begin pend[i] = 2; start_frame(i, 4); end
        run_until_idle("rr_order", 500);
        check("rr_grant_count", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) check("rr_grant_order", glog[k], exp_b[k]);
        check("rr_frame_cnt", 32'(FRAME_CNT), 32'd9);

        // FULL burst of 5 cycles in the middle of a frame
        cfg_len = 8; pend[1] = 1; start_frame(1, 8);
        burst_src = 1; burst_at = 3; burst_left = 5;
        run_until_idle("full_burst", 300);
        burst_src = -1;
        check("full_burst_frame_cnt", 32'(FRAME_CNT), exp_frames);

        // Watchdog: source 2 sends 12 words without early EOF, source 3 waits
        glog.delete();
        pend[2] = 1; start_frame(2, 12);
        pend[3] = 1; start_frame(3, 3);
        run_until_idle("watchdog", 300);
        check("wd_timeout_cnt", 32'(TIMEOUT_CNT), 32'd1);
        check("wd_grant_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("wd_first_grant", glog[0], 2);
            check("wd_next_grant", glog[1], 3);
        end

        // ENABLE dropped mid-frame with two requesters
        cfg_len = 6;
        pend[0] = 1; start_frame(0, 6);
        pend[1] = 1; start_frame(1, 6);
        n = 100;
        do begin drive_cycle(); n--; end while (!(GRANT[0] && fidx[0] >= 3) && n > 0);
        check("en_first_grant", 32'(GRANT), 32'h1);
        ENABLE = 1'b0;
        n = 100;
        do begin drive_cycle(); n--; end while (!(pend[0] == 0 && GRANT == '0) && n > 0);
        check("en_frame_done", pend[0], 0);
        repeat (5) begin
            drive_cycle();
            check("en_no_grant", 32'(GRANT), 32'd0);
        end
        ENABLE = 1'b1;
        @(posedge CK);
        #1;
        check("en_regrant", 32'(GRANT), 32'h2);
        run_until_idle("enable", 200);

        // Randomised traffic with FULL noise, ENABLE toggling and runaway frames
        cfg_len = 0;
        full_rand = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 7) == 0) begin
                    pend[i] = $urandom_range(1, 3);
                    start_frame(i, $urandom_range(1, 12));
                end
            end
            if ($urandom_range(0, 39) == 0) ENABLE = ~ENABLE;
            drive_cycle();
        end
        ENABLE = 1'b1;
        full_rand = 1'b0;
        run_until_idle("random", 2000);
        check("rand_frame_cnt", 32'(FRAME_CNT), exp_frames);
        check("rand_timeout_cnt", 32'(TIMEOUT_CNT), exp_timeouts);

        // Asynchronous reset in the middle of a frame
        cfg_len = 8; pend[0] = 1; start_frame(0, 8);
        n = 100;
        do begin drive_cycle(); n--; end while (fidx[0] < 3 && n > 0);
        #2;
        mon_en = 1'b0;
        RSTb = 1'b0;
        #1;
        check("mid_rst_grant", 32'(GRANT), 32'd0);
        check("mid_rst_out_wr", 32'(OUT_WR), 32'd0);
        check("mid_rst_out_eof", 32'(OUT_EOF), 32'd0);
        check("mid_rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
        check("mid_rst_timeout_cnt", 32'(TIMEOUT_CNT), 32'd0);
        check("mid_rst_src_full", 32'(SRC_FULL), 32'hF);
        for (int i = 0; i < N; i++) begin pend[i] = 0; blind[i] = 1'b0; end
        exp_q.delete();
        REQ = '0; SRC_WR = '0; SRC_EOF = '0;
        last_served = 0; exp_frames = 0; exp_timeouts = 0;
        @(negedge CK);
        RSTb = 1'b1;
        mon_en = 1'b1;

        // Pointer restarts at 0 after reset
        glog.delete();
        cfg_len = 2;
        for (int i = 0; i < N; i++) begin pend[i] = 1; start_frame(i, 2); end
        run_until_idle("post_reset", 300);
        if (glog.size() > 0) check("post_rst_first_grant", glog[0], exp_b[0]);
        else check("post_rst_grant_count", glog.size(), 4);
        check("post_rst_frame_cnt", 32'(FRAME_CNT), exp_frames);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
